// File: rtl/wb_scoreboard.sv
// wb_scoreboard: write-back arbiter (MEM over EX) onto the regfile write port
// with per-register pending-write counters for RAW stall detection.
module wb_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rd_we,
    output logic [ADDR_W-1:0] rd_waddr,
    output logic [DATA_W-1:0] rd_wdata,
    output logic [31:0]       wb_count,
    output logic              sb_err
);
    logic [CNT_W-1:0]  cnt_q [REG_NUM];
    logic [CNT_W-1:0]  cnt_d [REG_NUM];
    logic              rd_we_q, sb_err_q, sb_err_d;
    logic [ADDR_W-1:0] rd_waddr_q;
    logic [DATA_W-1:0] rd_wdata_q;
    logic [31:0]       wb_count_q;
    logic              acc_mem, acc_ex, wr_fire, iss_fire;
    logic [ADDR_W-1:0] acc_rd;
    logic [DATA_W-1:0] acc_data;

    assign mem_ready = !rst;
    assign ex_ready  = !rst && !mem_valid;
    assign acc_mem   = mem_valid && mem_ready;
    assign acc_ex    = ex_valid && ex_ready;
    assign acc_rd    = acc_mem ? mem_rd : ex_rd;
    assign acc_data  = acc_mem ? mem_data : ex_data;
    assign wr_fire   = (acc_mem || acc_ex) && acc_rd != '0;
    assign iss_ready = !(iss_rd != '0 && cnt_q[iss_rd] == '1);
    assign iss_fire  = iss_valid && iss_ready && iss_rd != '0;
    assign rs1_busy  = rs1_addr != '0 && cnt_q[rs1_addr] != '0;
    assign rs2_busy  = rs2_addr != '0 && cnt_q[rs2_addr] != '0;
    assign sb_err_d  = sb_err_q || (wr_fire && cnt_q[acc_rd] == '0);

    // A same-cycle issue and retire to one register cancel out
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < REG_NUM; r++) begin
            if (iss_fire && iss_rd == ADDR_W'(r) && !(wr_fire && acc_rd == ADDR_W'(r)))
                cnt_d[r] = cnt_q[r] + 1'b1;
            else if (wr_fire && acc_rd == ADDR_W'(r) && !(iss_fire && iss_rd == ADDR_W'(r)) && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= '0;
            rd_we_q    <= 1'b0;
            rd_waddr_q <= '0;
            rd_wdata_q <= '0;
            wb_count_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rd_we_q  <= wr_fire;
            sb_err_q <= sb_err_d;
            if (wr_fire) begin
                rd_waddr_q <= acc_rd;
                rd_wdata_q <= acc_data;
                wb_count_q <= wb_count_q + 32'd1;
            end
        end
    end

    assign rd_we    = rd_we_q;
    assign rd_waddr = rd_waddr_q;
    assign rd_wdata = rd_wdata_q;
    assign wb_count = wb_count_q;
    assign sb_err   = sb_err_q;
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: directed vectors with hand-computed expectations for wb_scoreboard.
module tb_wb_scoreboard;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ex_valid = 1'b0, mem_valid = 1'b0, iss_valid = 1'b0;
    logic        ex_ready, mem_ready, iss_ready, rs1_busy, rs2_busy, rd_we, sb_err;
    logic [4:0]  ex_rd = '0, mem_rd = '0, iss_rd = '0, rs1_addr = '0, rs2_addr = '0, rd_waddr;
    logic [31:0] ex_data = '0, mem_data = '0, rd_wdata, wb_count;
    int          checks = 0, failures = 0;

    wb_scoreboard dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rd(iss_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .wb_count(wb_count), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        mem_valid = 1'b0;
        iss_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", rd_we, 0);
        check("rst_count", wb_count, 0);
        check("rst_err", sb_err, 0);
        check("rst_mem_ready", mem_ready, 0);
        rst = 1'b0;
        #1;
        check("mem_ready", mem_ready, 1);

        // issue x5, then EX result 0x1234
        rs1_addr = 5;
        iss_valid = 1'b1; iss_rd = 5;
        #1 check("iss5_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
        ex_valid = 1'b1; ex_rd = 5; ex_data = 32'h1234;
        #1;
        check("x5_busy_pre", rs1_busy, 1);
        check("x5_ex_ready", ex_ready, 1);
        tick();
        idle();
        check("x5_we", rd_we, 1);
        check("x5_waddr", rd_waddr, 5);
        check("x5_wdata", rd_wdata, 32'h1234);
        check("x5_busy_wb", rs1_busy, 0);
        check("x5_count", wb_count, 1);
        tick();
        check("x5_we_drop", rd_we, 0);

        // MEM beats EX in the same cycle
        iss_valid = 1'b1; iss_rd = 3;
        tick();
        iss_rd = 4;
        tick();
        iss_valid = 1'b0;
        ex_valid = 1'b1; ex_rd = 3; ex_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 4; mem_data = 32'h44;
        #1;
        check("arb_ex_ready", ex_ready, 0);
        check("arb_mem_ready", mem_ready, 1);
        tick();
        mem_valid = 1'b0;
        check("arb_mem_waddr", rd_waddr, 4);
        check("arb_mem_wdata", rd_wdata, 32'h44);
        #1 check("arb_ex_ready2", ex_ready, 1);
        tick();
        idle();
        check("arb_ex_we", rd_we, 1);
        check("arb_ex_waddr", rd_waddr, 3);
        check("arb_ex_wdata", rd_wdata, 32'h33);
        check("arb_count", wb_count, 3);
        check("arb_err", sb_err, 0);

        // fill x7 counter to its maximum
        rs1_addr = 7;
        iss_valid = 1'b1; iss_rd = 7;
        for (int i = 0; i < 3; i++) begin
            #1 check("x7_ready_fill", iss_ready, 1);
            tick();
        end
        check("x7_full", iss_ready, 0);
        mem_valid = 1'b1; mem_rd = 7; mem_data = 32'h77;
        #1 check("x7_full_retire", iss_ready, 0);
        tick();
        idle();
        check("x7_ready_after", iss_ready, 1);
        check("x7_busy", rs1_busy, 1);
        check("x7_count", wb_count, 4);

        // same-cycle issue/retire x9
        rs2_addr = 9;
        iss_valid = 1'b1; iss_rd = 9;
        tick();
        ex_valid = 1'b1; ex_rd = 9; ex_data = 32'h99;
        #1 check("x9_iss_ready", iss_ready, 1);
        tick();
        idle();
        check("x9_busy_hold", rs2_busy, 1);
        check("x9_we", rd_we, 1);
        check("x9_waddr", rd_waddr, 9);
        ex_valid = 1'b1;
        tick();
        idle();
        check("x9_busy_clear", rs2_busy, 0);
        check("x9_count", wb_count, 6);

        // x0 result is consumed silently
        ex_valid = 1'b1; ex_rd = 0; ex_data = 32'hDEAD;
        #1 check("x0_ex_ready", ex_ready, 1);
        tick();
        idle();
        check("x0_we", rd_we, 0);
        check("x0_count", wb_count, 6);

        // retire to x6 with nothing pending
        ex_valid = 1'b1; ex_rd = 6; ex_data = 32'h66;
        tick();
        idle();
        check("x6_err", sb_err, 1);
        check("x6_we", rd_we, 1);
        check("x6_wdata", rd_wdata, 32'h66);
        check("x6_count", wb_count, 7);
        tick();
        check("x6_err_sticky", sb_err, 1);

        // async reset mid-write with cnt[5]=2
        rs1_addr = 5;
        iss_valid = 1'b1; iss_rd = 5;
        repeat (2) tick();
        ex_valid = 1'b1; ex_rd = 5; ex_data = 32'h55;
        tick();
        idle();
        check("pre_rst_we", rd_we, 1);
        check("pre_rst_busy", rs1_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_we", rd_we, 0);
        check("arst_waddr", rd_waddr, 0);
        check("arst_wdata", rd_wdata, 0);
        check("arst_count", wb_count, 0);
        check("arst_err", sb_err, 0);
        check("arst_busy", rs1_busy, 0);
        check("arst_mem_ready", mem_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", rs1_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
